// File: rtl/b01_pkg.sv
// Shared definitions for the b01 operand serializer slice.
//   state_e        : serializer FSM states
//   DEFAULT_WIDTH  : default operand/frame width
//   bit_index()    : operand bit position emitted at serial step cnt
package b01_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned bit_index(
        input int unsigned cnt,
        input bit          msb_first,
        input int unsigned width = DEFAULT_WIDTH
    );
        return msb_first ? (width - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/b01_piso.sv
// Parallel-in serial-out register.
//   clock     : rising-edge clock
//   reset     : synchronous active-low clear
//   load      : capture load_data (has priority over shift)
//   shift     : advance one bit, filling with 0
//   load_data : parallel word
//   sout      : current serial bit, taken straight from the register
// Zero fill means the register is all-zero once a frame has fully shifted
// out, so sout idles at 0 without any output gating.
module b01_piso
    import b01_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout
);

    localparam int unsigned TAP = bit_index(0, MSB_FIRST, WIDTH);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = load_data;
        end else if (shift) begin
            if (MSB_FIRST) begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
            end else begin
                sh_d = {1'b0, sh_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign sout = sh_q[TAP];

endmodule

// File: rtl/b01_operand_serializer.sv
// Serializes (A,B) operand pairs onto line1/line2, one bit pair per clock.
//   clock/reset      : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready: input handshake, transfer on in_valid && in_ready
//   in_a/in_b        : operand words for line1/line2
//   line1/line2      : registered serial bits
//   frame_start/last : registered markers for the first/last bit of a frame
//   busy             : registered, high in SHIFT or GAP
// One pending word lets the next frame load at the boundary without a bubble.
module b01_operand_serializer
    import b01_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned IDLE_BITS = 0,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             line1,
    output logic             line2,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned   GW       = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

    state_e           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] pend_a_q, pend_a_d;
    logic [WIDTH-1:0] pend_b_q, pend_b_d;
    logic             pend_full_q, pend_full_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_last_q, frame_last_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             have_src;
    logic [WIDTH-1:0] src_a, src_b;
    logic             load, shift;

    assign in_ready = reset && !pend_full_q;

    always_comb begin
        accept   = in_valid && in_ready;
        have_src = pend_full_q || accept;
        src_a    = pend_full_q ? pend_a_q : in_a;
        src_b    = pend_full_q ? pend_b_q : in_b;

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift     = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_LAST) begin
                    if ((IDLE_BITS == 0) && have_src) begin
                        load      = 1'b1;
                        shift     = 1'b0;
                        bit_cnt_d = '0;
                    end else if (IDLE_BITS > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    if (have_src) begin
                        load      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pending is drained by a load that uses it; an accepted word that is
        // not loaded directly this cycle is parked in pending.
        pend_a_d    = pend_a_q;
        pend_b_d    = pend_b_q;
        pend_full_d = pend_full_q;
        if (load && pend_full_q) begin
            pend_full_d = 1'b0;
        end
        if (accept && !(load && !pend_full_q)) begin
            pend_a_d    = in_a;
            pend_b_d    = in_b;
            pend_full_d = 1'b1;
        end

        frame_start_d = (state_d == ST_SHIFT) && (bit_cnt_d == '0);
        frame_last_d  = (state_d == ST_SHIFT) && (bit_cnt_d == CNT_LAST);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            pend_a_q      <= '0;
            pend_b_q      <= '0;
            pend_full_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            pend_a_q      <= pend_a_d;
            pend_b_q      <= pend_b_d;
            pend_full_q   <= pend_full_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
            busy_q        <= busy_d;
        end
    end

    b01_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST != 0)
    ) u_piso_a (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .load_data (src_a),
        .sout      (line1)
    );

    b01_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST != 0)
    ) u_piso_b (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .load_data (src_b),
        .sout      (line2)
    );

    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_b01_operand_serializer.sv
// Two serializers share one input stream: d0 (IDLE_BITS=0, LSB first) and
// d1 (IDLE_BITS=3, MSB first). Each is compared every cycle against a
// queue-based frame model of its own configuration.
module tb_b01_operand_serializer;

    localparam int W = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_a, in_b;
    logic       rdy [2];
    logic       l1  [2];
    logic       l2  [2];
    logic       fs  [2];
    logic       fl  [2];
    logic       bz  [2];

    always #5 clock = ~clock;

    b01_operand_serializer #(.WIDTH(8), .IDLE_BITS(0), .MSB_FIRST(0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .line1(l1[0]), .line2(l2[0]),
        .frame_start(fs[0]), .frame_last(fl[0]), .busy(bz[0])
    );

    b01_operand_serializer #(.WIDTH(8), .IDLE_BITS(3), .MSB_FIRST(1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a), .in_b(in_b), .line1(l1[1]), .line2(l2[1]),
        .frame_start(fs[1]), .frame_last(fl[1]), .busy(bz[1])
    );

    // Reference model: words waiting, word on the lines, bit position, gap left
    logic [15:0] m_wait [2][$];
    bit          m_in   [2];
    int          m_pos  [2];
    int          m_gap  [2];
    logic [15:0] m_word [2];

    logic smp_l1 [2];
    logic smp_l2 [2];
    logic smp_fs [2];
    logic smp_bz [2];
    bit   last_acc [2];

    int ncomp = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear(input int d);
        m_wait[d].delete();
        m_in[d]   = 1'b0;
        m_pos[d]  = 0;
        m_gap[d]  = 0;
        m_word[d] = '0;
    endfunction

    function automatic void start_next(input int d);
        if (m_wait[d].size() > 0) begin
            m_word[d] = m_wait[d].pop_front();
            m_in[d]   = 1'b1;
            m_pos[d]  = 0;
        end
    endfunction

    function automatic void model_edge(input int d, input bit r, input bit acc, input logic [15:0] w);
        int gapcfg;
        gapcfg = (d == 1) ? 3 : 0;
        if (!r) begin
            model_clear(d);
            return;
        end
        if (acc) m_wait[d].push_back(w);
        if (m_in[d]) begin
            m_pos[d]++;
            if (m_pos[d] == W) begin
                m_in[d] = 1'b0;
                if (gapcfg > 0) m_gap[d] = gapcfg;
                else start_next(d);
            end
        end else if (m_gap[d] > 0) begin
            m_gap[d]--;
            if (m_gap[d] == 0) start_next(d);
        end else begin
            start_next(d);
        end
    endfunction

    task automatic check_outputs(input int d);
        logic [7:0] wa, wb;
        int         idx;
        logic       e1, e2, efs, efl, ebz;
        wa  = m_word[d][15:8];
        wb  = m_word[d][7:0];
        idx = (d == 1) ? (W - 1 - m_pos[d]) : m_pos[d];
        e1  = m_in[d] ? wa[idx] : 1'b0;
        e2  = m_in[d] ? wb[idx] : 1'b0;
        efs = m_in[d] && (m_pos[d] == 0);
        efl = m_in[d] && (m_pos[d] == W - 1);
        ebz = m_in[d] || (m_gap[d] > 0);
        chk($sformatf("d%0d_line1", d), 16'(l1[d]), 16'(e1));
        chk($sformatf("d%0d_line2", d), 16'(l2[d]), 16'(e2));
        chk($sformatf("d%0d_frame_start", d), 16'(fs[d]), 16'(efs));
        chk($sformatf("d%0d_frame_last", d), 16'(fl[d]), 16'(efl));
        chk($sformatf("d%0d_busy", d), 16'(bz[d]), 16'(ebz));
        smp_l1[d] = l1[d];
        smp_l2[d] = l2[d];
        smp_fs[d] = fs[d];
        smp_bz[d] = bz[d];
    endtask

    // One clock: check outputs of the previous edge, drive, check in_ready, clock, update model.
    task automatic step(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b);
        bit exp_rdy;
        @(negedge clock);
        for (int d = 0; d < 2; d++) check_outputs(d);
        reset    = r;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rdy = r && (m_wait[d].size() == 0);
            chk($sformatf("d%0d_in_ready", d), 16'(rdy[d]), 16'(exp_rdy));
            last_acc[d] = v && exp_rdy;
        end
        @(posedge clock);
        for (int d = 0; d < 2; d++) model_edge(d, r, last_acc[d], {a, b});
    endtask

    initial begin
        int         nfs;
        int         nbz;
        int         guard;
        logic [7:0] cap_a, cap_b;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        for (int d = 0; d < 2; d++) model_clear(d);
        repeat (2) @(posedge clock);

        // Reset held: outputs idle, in_ready low even with valid offered
        step(1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'h11, 8'h22);
        step(1'b1, 1'b0, 8'h00, 8'h00);

        // Single word A5/3C
        step(1'b1, 1'b1, 8'hA5, 8'h3C);
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            cap_a[j] = smp_l1[0];
            cap_b[j] = smp_l2[0];
        end
        chk("single_line1_bits", 16'(cap_a), 16'h00A5);
        chk("single_line2_bits", 16'(cap_b), 16'h003C);
        repeat (6) step(1'b1, 1'b0, 8'h00, 8'h00);

        // MSB first on d1: 0x80 gives 1 then seven 0s
        step(1'b1, 1'b1, 8'h80, 8'h01);
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            cap_a = {cap_a[6:0], smp_l1[1]};
        end
        chk("msb_first_line1", 16'(cap_a), 16'h0080);
        repeat (6) step(1'b1, 1'b0, 8'h00, 8'h00);

        // Back-to-back on d0, gap insertion on d1
        step(1'b1, 1'b1, 8'hFF, 8'h00);
        step(1'b1, 1'b1, 8'h01, 8'h80);
        nfs = int'(smp_fs[0]);
        nbz = int'(smp_bz[0]);
        for (int j = 0; j < 15; j++) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            nfs += int'(smp_fs[0]);
            nbz += int'(smp_bz[0]);
        end
        chk("b2b_frame_starts", 16'(nfs), 16'd2);
        chk("b2b_busy_cycles", 16'(nbz), 16'd16);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("b2b_idle_after", 16'(smp_bz[0]), 16'd0);
        repeat (8) step(1'b1, 1'b0, 8'h00, 8'h00);

        // Backpressure: three words offered during the first frame
        step(1'b1, 1'b1, 8'hC1, 8'h1C);
        for (int i = 0; i < 2; i++) begin
            guard = 0;
            do begin
                step(1'b1, 1'b1, (i == 0) ? 8'h5A : 8'hE7, (i == 0) ? 8'h96 : 8'h7E);
                guard++;
            end while (!last_acc[0] && guard < 40);
            chk("bp_accept_bounded", 16'(guard < 40), 16'd1);
        end
        repeat (30) step(1'b1, 1'b0, 8'h00, 8'h00);

        // Reset at bit 4 with a pending word
        step(1'b1, 1'b1, 8'hAA, 8'h55);
        step(1'b1, 1'b1, 8'h0F, 8'hF0);
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        nfs = 0;
        for (int j = 0; j < 20; j++) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            nfs += int'(smp_fs[0]) + int'(smp_fs[1]);
        end
        chk("reset_drops_pending", 16'(nfs), 16'd0);

        // Randomized traffic with occasional resets
        for (int j = 0; j < 600; j++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                 8'($urandom), 8'($urandom));
        end
        repeat (30) step(1'b1, 1'b0, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/b01_operand_serializer.md
# b01_operand_serializer

Upstream feeder for the b01 serial-flow FSM. Accepts pairs of parallel operand words over a valid/ready handshake and shifts them out bit-serially on `line1`/`line2`, one bit pair per clock, with optional idle gaps between frames. A one-word pending buffer allows back-to-back frames with no bubble. Outputs are registered so they can drive the b01 inputs directly.

## Interface
- `WIDTH`, 8: bits per operand word and per serial frame; must be ≥ 2.
- `IDLE_BITS`, 0: cycles of `line1=line2=0` inserted after every frame; 0 means frames may abut.
- `MSB_FIRST`, 0: 0 shifts bit 0 first; 1 shifts bit WIDTH-1 first.
- `clock`  in  1  single clock, all state updates on the rising edge.
- `reset`  in  1  synchronous reset, active-low; 0 at a rising edge clears all state.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_a`  in  WIDTH  operand driven on `line1`.
- `in_b`  in  WIDTH  operand driven on `line2`.
- `line1`  out  1  serial bit of A, registered.
- `line2`  out  1  serial bit of B, registered.
- `frame_start`  out  1  high while the first bit of a frame is on the lines.
- `frame_last`  out  1  high while the last bit of a frame is on the lines.
- `busy`  out  1  high in SHIFT or GAP.

## Operation
- State: active shift registers `sh_a`/`sh_b`, bit counter `bit_cnt` (clog2(WIDTH) bits), gap counter, pending buffer (`pend_a`, `pend_b`, `pend_full`), FSM {IDLE, SHIFT, GAP}.
- `in_ready = reset && !pend_full`; combinational, no dependence on `in_valid`.
- Load source at a frame boundary: pending buffer if `pend_full`, else the word accepted in that same cycle.
- IDLE: on accept, load shift regs, `bit_cnt=0`, go SHIFT. Lines drive 0.
- SHIFT: lines carry the current bit and `bit_cnt` increments each cycle. An accept during SHIFT that is not taken as a load source writes the pending buffer.
- SHIFT at the last bit (`bit_cnt==WIDTH-1`):
  - If `IDLE_BITS==0` and a load source exists: reload, `bit_cnt=0`, stay SHIFT (seamless).
  - Else if `IDLE_BITS>0`: go GAP.
  - Else: go IDLE.
- GAP: lines 0 for exactly IDLE_BITS cycles. Accepts go to pending. After the last gap cycle, go SHIFT with a load source if one exists, else IDLE.
- When the pending buffer is consumed in the same cycle a new word is accepted, the new word goes into pending and `pend_full` stays 1.
- Reset mid-frame aborts the frame, discards pending data, and drives lines to 0 in the next cycle. No partial-frame recovery.

## Timing
- Reset values: `line1=line2=0`, `frame_start=frame_last=0`, `busy=0`, `pend_full=0`, FSM=IDLE. `in_ready=0` while reset is low and 1 from the first cycle after release.
- Latency: accept at edge k puts the first bit on the lines during cycle k+1 (IDLE case).
- Frame occupies exactly WIDTH consecutive cycles. `frame_start` and `frame_last` are each one cycle wide.
- Throughput: with `IDLE_BITS=0` and a continuously valid source, one frame every WIDTH cycles with no gap. Otherwise one frame every WIDTH+IDLE_BITS cycles.
- At most two words are held at once (active + pending). `in_ready` drops the cycle after pending fills.

## Structure
- Shared package `b01_pkg` holds:
  - the state enum {IDLE, SHIFT, GAP};
  - default `WIDTH`;
  - a `bit_index(cnt, msb_first)` function.
- One natural sub-module, `b01_piso`: a WIDTH-bit parallel-in serial-out register with load/shift and MSB_FIRST. It is instantiated twice (A, B). Counters, FSM and pending buffer stay in the top.

## Test plan
- Reset then single word: `WIDTH=8`, `in_a=0xA5`, `in_b=0x3C`, accept at edge k → `line1` = 1,0,1,0,0,1,0,1 and `line2` = 0,0,1,1,1,1,0,0 on cycles k+1..k+8. `frame_start` at k+1, `frame_last` at k+8, then lines 0 and `busy=0`.
- Back-to-back with `IDLE_BITS=0`: `in_valid` held with words 0xFF/0x00 then 0x01/0x80 → 16 consecutive bit cycles, no gap. `frame_start` at cycles 1 and 9.
- Gap insertion with `IDLE_BITS=3`: two queued words → 8 bits, 3 zero cycles, 8 bits. `busy` stays 1 throughout.
- Backpressure: offer 3 words during the first frame → `in_ready` low after the second accept until the pending word loads. The third word is emitted third, with no loss or duplication.
- MSB_FIRST=1: `in_a=0x80` → `line1` is 1 in the first bit cycle and 0 for the remaining 7.
- Reset at bit 4 of a frame with a pending word → lines 0 next cycle, `in_ready=1` after release, and the pending word is never emitted.
